// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single register-file write port between NREQ writeback
//   requesters (ALU, load, debug/host, ...). Requesters are granted
//   round-robin and the winning write is registered one cycle before it
//   reaches the RF. A per-register pending scoreboard lets decode stall
//   reads of registers that still have a write outstanding.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   req_valid  [NREQ]      requester i has a write pending
//   req_addr   [5*NREQ]    destination reg of requester i, bits [5i+4:5i]
//   req_data   [32*NREQ]   write data of requester i, bits [32i+31:32i]
//   req_ready  [NREQ]      one-hot grant, transfer when valid & ready
//   rf_we      RF write enable (registered)
//   rf_waddr   RF write address (registered)
//   rf_wdata   RF write data (registered)
//   rsv_en     reserve a destination reg at issue (sets pending)
//   rsv_addr   reg being reserved
//   q1_addr    source reg query 1
//   q2_addr    source reg query 2
//   q1_busy    pending[q1_addr], combinational
//   q2_busy    pending[q2_addr], combinational
//   any_busy   OR of all pending bits

module rf_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,

  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,

  input  logic                 rsv_en,
  input  logic [4:0]           rsv_addr,
  input  logic [4:0]           q1_addr,
  input  logic [4:0]           q2_addr,
  output logic                 q1_busy,
  output logic                 q2_busy,
  output logic                 any_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // ------------------------------------------------------------------
  // Requester unpacking
  // ------------------------------------------------------------------
  logic [4:0]  addr_arr [NREQ];
  logic [31:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[5*gi +: 5];
    assign data_arr[gi] = req_data[32*gi +: 32];
  end

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [PW-1:0] ptr_q,      ptr_d;
  logic          rf_we_q,    rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic [31:0]   pending_q,  pending_d;

  // ------------------------------------------------------------------
  // Round-robin grant: scan from ptr upward, wrapping at NREQ.
  // The candidate index is ptr+off reduced modulo NREQ; since ptr < NREQ
  // a single conditional subtract is enough.
  // ------------------------------------------------------------------
  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   cand;
  logic          xfer;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(off);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!gnt_found && req_valid[cand[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PW-1:0];
      end
    end
  end

  // No grant is offered while reset is asserted, so nothing is lost by a
  // requester that sees ready during the reset cycle.
  assign xfer = gnt_found && !rst;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Pointer and write stage
  // ------------------------------------------------------------------
  always_comb begin
    ptr_d      = ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      ptr_d      = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
      // Writes to r0 are accepted and consumed, but never reach the RF.
      rf_we_d    = (addr_arr[gnt_idx] != 5'd0);
      rf_waddr_d = addr_arr[gnt_idx];
      rf_wdata_d = data_arr[gnt_idx];
    end
  end

  // ------------------------------------------------------------------
  // Pending scoreboard
  // Clear happens on the edge the RF captures the data; a reservation on
  // the same edge is applied afterwards so the newer one stays outstanding.
  // ------------------------------------------------------------------
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[rf_waddr_q] = 1'b0;
    end
    if (rsv_en) begin
      pending_d[rsv_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
      pending_q  <= 32'd0;
    end else begin
      ptr_q      <= ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // No bypass: busy drops only once the RF already holds the new value.
  assign q1_busy  = pending_q[q1_addr];
  assign q2_busy  = pending_q[q2_addr];
  assign any_busy = |pending_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int N = 3;

  localparam bit [31:0] DA = 32'hA000_0001;
  localparam bit [31:0] DB = 32'hB000_0002;
  localparam bit [31:0] DC = 32'hC000_0003;
  localparam bit [31:0] T1 = 32'h1234_ABCD;
  localparam bit [31:0] S7 = 32'h7070_7070;
  localparam bit [31:0] U7 = 32'h7777_7777;
  localparam bit [31:0] N9 = 32'h9999_9999;
  localparam bit [31:0] FF = 32'hFFFF_FFFF;

  logic            clk;
  logic            rst;
  logic [N-1:0]    vld;
  logic [4:0]      a [N];
  logic [31:0]     d [N];
  logic            rsv_en;
  logic [4:0]      rsv_addr;
  logic [4:0]      q1_addr;
  logic [4:0]      q2_addr;

  logic [5*N-1:0]  req_addr;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            q1_busy, q2_busy, any_busy;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  rf_wb_arbiter #(.NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (vld),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .q1_addr   (q1_addr),
    .q2_addr   (q2_addr),
    .q1_busy   (q1_busy),
    .q2_busy   (q2_busy),
    .any_busy  (any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------
  // Vector table
  // ------------------------------------------------------------------
  typedef struct {
    bit        rst;
    bit [2:0]  vld;
    bit [4:0]  a0, a1, a2;
    bit [31:0] d0, d1, d2;
    bit        rsv_en;
    bit [4:0]  rsv_a;
    bit [4:0]  q1, q2;
    bit [2:0]  e_rdy;
    bit        e_we;
    bit [4:0]  e_waddr;
    bit [31:0] e_wdata;
    bit        e_q1b, e_q2b, e_any;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    bit [31:0] r, bit [31:0] v, bit [31:0] a0, bit [31:0] a1, bit [31:0] a2,
    bit [31:0] d0, bit [31:0] d1, bit [31:0] d2,
    bit [31:0] re, bit [31:0] ra, bit [31:0] q1, bit [31:0] q2,
    bit [31:0] erdy, bit [31:0] ewe, bit [31:0] ewa, bit [31:0] ewd,
    bit [31:0] eq1, bit [31:0] eq2, bit [31:0] eany);
    vec_t x;
    x.rst = r[0];   x.vld = v[2:0];
    x.a0 = a0[4:0]; x.a1 = a1[4:0]; x.a2 = a2[4:0];
    x.d0 = d0;      x.d1 = d1;      x.d2 = d2;
    x.rsv_en = re[0]; x.rsv_a = ra[4:0];
    x.q1 = q1[4:0]; x.q2 = q2[4:0];
    x.e_rdy = erdy[2:0]; x.e_we = ewe[0]; x.e_waddr = ewa[4:0]; x.e_wdata = ewd;
    x.e_q1b = eq1[0]; x.e_q2b = eq2[0]; x.e_any = eany[0];
    return x;
  endfunction

  // ------------------------------------------------------------------
  // Reference model: round-robin list scan plus an array of pending flags
  // ------------------------------------------------------------------
  int        m_ptr;
  bit        m_we;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  bit        m_pend [32];
  int        m_last_g;
  logic [2:0] last_dut_rdy;

  int n_cmp = 0;
  int n_err = 0;

  function automatic int model_grant();
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (vld[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit model_any();
    for (int k = 0; k < 32; k++) if (m_pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(input int g);
    bit np [32];
    if (rst) begin
      m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
      for (int k = 0; k < 32; k++) m_pend[k] = 0;
    end else begin
      np = m_pend;
      if (m_we) np[m_waddr] = 0;
      if (rsv_en && rsv_addr != 0) np[rsv_addr] = 1;
      m_pend = np;
      if (g >= 0) begin
        m_we    = (a[g] != 0);
        m_waddr = a[g];
        m_wdata = d[g];
        m_ptr   = (g + 1) % N;
      end else begin
        m_we = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: dut=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // mode 0: advance only, 1: check against table row, 2: check against model
  task automatic cycle(input int mode, input vec_t v);
    int g;
    logic [2:0] e_rdy;
    #1;
    g = model_grant();
    e_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
    last_dut_rdy = req_ready;
    if (mode == 1) begin
      chk("tbl_ready",  {29'd0, req_ready}, {29'd0, v.e_rdy});
      chk("tbl_rf_we",  {31'd0, rf_we},     {31'd0, v.e_we});
      chk("tbl_waddr",  {27'd0, rf_waddr},  {27'd0, v.e_waddr});
      chk("tbl_wdata",  rf_wdata,           v.e_wdata);
      chk("tbl_q1busy", {31'd0, q1_busy},   {31'd0, v.e_q1b});
      chk("tbl_q2busy", {31'd0, q2_busy},   {31'd0, v.e_q2b});
      chk("tbl_any",    {31'd0, any_busy},  {31'd0, v.e_any});
    end else if (mode == 2) begin
      chk("mdl_ready",  {29'd0, req_ready}, {29'd0, e_rdy});
      chk("mdl_rf_we",  {31'd0, rf_we},     {31'd0, m_we});
      chk("mdl_waddr",  {27'd0, rf_waddr},  {27'd0, m_waddr});
      chk("mdl_wdata",  rf_wdata,           m_wdata);
      chk("mdl_q1busy", {31'd0, q1_busy},   {31'd0, m_pend[q1_addr]});
      chk("mdl_q2busy", {31'd0, q2_busy},   {31'd0, m_pend[q2_addr]});
      chk("mdl_any",    {31'd0, any_busy},  {31'd0, model_any()});
    end
    m_last_g = g;
    model_update(g);
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; vld = v.vld;
    a[0] = v.a0; a[1] = v.a1; a[2] = v.a2;
    d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
    rsv_en = v.rsv_en; rsv_addr = v.rsv_a;
    q1_addr = v.q1; q2_addr = v.q2;
  endtask

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  vec_t dummy;
  bit   hv [N];
  bit   seen;
  int   k_seen;

  initial begin
    rst = 1'b1; vld = '0; rsv_en = 1'b0; rsv_addr = '0; q1_addr = '0; q2_addr = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    dummy = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_last_g = -1;
    for (int k = 0; k < 32; k++) m_pend[k] = 0;

    //          rst vld    a0 a1 a2 d0  d1  d2  rsv ra q1 q2  rdy    we wa wd  q1b q2b any
    tv.push_back(mk(1,'b111, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b000, 0, 0, 0,  0, 0, 0));
    // single requester, reserve + write reg 5, busy window
    tv.push_back(mk(0,'b001, 5, 0, 0, T1, 0,  0,  1, 5, 5, 0, 'b001, 0, 0, 0,  0, 0, 0));
    tv.push_back(mk(0,'b000, 5, 0, 0, T1, 0,  0,  0, 0, 5, 0, 'b000, 1, 5, T1, 1, 0, 1));
    tv.push_back(mk(0,'b000, 5, 0, 0, T1, 0,  0,  0, 0, 5, 0, 'b000, 0, 5, T1, 0, 0, 0));
    // bring pointer back to 0 via req2
    tv.push_back(mk(0,'b100, 0, 0, 3, 0,  0,  DC, 0, 0, 5, 0, 'b100, 0, 5, T1, 0, 0, 0));
    // all three valid: 0,1,2,0,1,2
    tv.push_back(mk(0,'b111, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b001, 1, 3, DC, 0, 0, 0));
    tv.push_back(mk(0,'b111, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b010, 1, 1, DA, 0, 0, 0));
    tv.push_back(mk(0,'b111, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b100, 1, 2, DB, 0, 0, 0));
    tv.push_back(mk(0,'b111, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b001, 1, 3, DC, 0, 0, 0));
    tv.push_back(mk(0,'b111, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b010, 1, 1, DA, 0, 0, 0));
    tv.push_back(mk(0,'b111, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b100, 1, 2, DB, 0, 0, 0));
    // only req2, then req0+req1
    tv.push_back(mk(0,'b100, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b100, 1, 3, DC, 0, 0, 0));
    tv.push_back(mk(0,'b011, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b001, 1, 3, DC, 0, 0, 0));
    tv.push_back(mk(0,'b010, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b010, 1, 1, DA, 0, 0, 0));
    tv.push_back(mk(0,'b000, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b000, 1, 2, DB, 0, 0, 0));
    tv.push_back(mk(0,'b000, 1, 2, 3, DA, DB, DC, 0, 0, 0, 0, 'b000, 0, 2, DB, 0, 0, 0));
    // write to r0 and reserve r0: both invisible
    tv.push_back(mk(0,'b010, 0, 0, 0, 0,  FF, 0,  1, 0, 0, 0, 'b010, 0, 2, DB, 0, 0, 0));
    tv.push_back(mk(0,'b000, 0, 0, 0, 0,  FF, 0,  0, 0, 0, 0, 'b000, 0, 0, FF, 0, 0, 0));
    // same-edge clear and reserve of reg 7
    tv.push_back(mk(0,'b000, 0, 0, 0, 0,  0,  0,  1, 7, 0, 7, 'b000, 0, 0, FF, 0, 0, 0));
    tv.push_back(mk(0,'b001, 7, 0, 0, S7, 0,  0,  0, 0, 0, 7, 'b001, 0, 0, FF, 0, 1, 1));
    tv.push_back(mk(0,'b000, 7, 0, 0, S7, 0,  0,  1, 7, 0, 7, 'b000, 1, 7, S7, 0, 1, 1));
    tv.push_back(mk(0,'b000, 7, 0, 0, S7, 0,  0,  0, 0, 0, 7, 'b000, 0, 7, S7, 0, 1, 1));
    tv.push_back(mk(0,'b010, 0, 7, 0, 0,  U7, 0,  0, 0, 0, 7, 'b010, 0, 7, S7, 0, 1, 1));
    tv.push_back(mk(0,'b000, 0, 7, 0, 0,  U7, 0,  0, 0, 0, 7, 'b000, 1, 7, U7, 0, 1, 1));
    tv.push_back(mk(0,'b000, 0, 7, 0, 0,  U7, 0,  0, 0, 0, 7, 'b000, 0, 7, U7, 0, 0, 0));
    // reset one cycle after a grant
    tv.push_back(mk(0,'b001, 9, 0, 0, N9, 0,  0,  1, 9, 9, 0, 'b001, 0, 7, U7, 0, 0, 0));
    tv.push_back(mk(1,'b011, 1, 2, 0, DA, DB, 0,  0, 0, 9, 0, 'b000, 1, 9, N9, 1, 0, 1));
    tv.push_back(mk(0,'b111, 1, 2, 3, DA, DB, DC, 0, 0, 9, 0, 'b001, 0, 0, 0,  0, 0, 0));
    tv.push_back(mk(0,'b000, 1, 2, 3, DA, DB, DC, 0, 0, 9, 0, 'b000, 1, 1, DA, 0, 0, 0));

    @(negedge clk);
    cycle(0, dummy);
    cycle(0, dummy);

    foreach (tv[i]) begin
      apply(tv[i]);
      cycle(1, tv[i]);
    end

    // Fairness under constant contention: req2 must win within N cycles.
    rst = 1'b0; vld = 3'b111; rsv_en = 1'b0;
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    d[0] = DA;   d[1] = DB;   d[2] = DC;
    seen = 1'b0; k_seen = -1;
    for (int k = 0; k < 8; k++) begin
      cycle(2, dummy);
      if (last_dut_rdy[2]) begin
        seen = 1'b1; k_seen = k;
        break;
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL fair_req2: no grant within 8 cycles, required within %0d", N);
    end else begin
      chk("fair_req2_cycle", k_seen, 1);
    end

    // Randomized traffic with requesters holding requests until granted.
    for (int i = 0; i < N; i++) hv[i] = vld[i];
    if (m_last_g >= 0) hv[m_last_g] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        if (!hv[i] && $urandom_range(0, 2) != 0) begin
          hv[i] = 1'b1;
          a[i]  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                              : 5'($urandom_range(0, 7));
          d[i]  = $urandom;
        end
        vld[i] = hv[i];
      end
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      q1_addr  = 5'($urandom_range(0, 7));
      q2_addr  = 5'($urandom_range(0, 7));
      cycle(2, dummy);
      if (m_last_g >= 0) hv[m_last_g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
